// File: rtl/vdu_console_writer.sv
// VDU console writer: converts a character byte stream into display-RAM
// writes, tracks the cursor, and scrolls by rotating a circular top-row
// pointer instead of moving RAM contents.
module vdu_console_writer #(
  parameter int unsigned COLS      = 60,
  parameter int unsigned ROWS      = 34,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDRW     = 16,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [7:0]              i_data,
  output logic                    o_ready,
  output logic                    o_write_en,
  output logic [ADDRW-1:0]        o_write_addr,
  output logic [7:0]              o_write_data,
  output logic [$clog2(ROWS)-1:0] o_top_row,
  output logic [$clog2(COLS)-1:0] o_cur_col,
  output logic [$clog2(ROWS)-1:0] o_cur_row,
  output logic                    o_busy
);

  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned NW    = $clog2(CELLS + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [NW-1:0] COLS_N   = NW'(COLS);
  localparam logic [NW-1:0] CELLS_N  = NW'(CELLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR_ROW,
    S_CLEAR_ALL
  } state_t;

  state_t r_state, w_state_nxt;

  logic             r_ready, r_busy, r_we;
  logic [ADDRW-1:0] r_addr;
  logic [7:0]       r_data;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row, r_top, r_fill;
  logic [NW-1:0]    r_cnt;

  logic             w_ready_nxt, w_busy_nxt, w_we_nxt;
  logic [ADDRW-1:0] w_addr_nxt;
  logic [7:0]       w_data_nxt;
  logic [CW-1:0]    w_col_nxt;
  logic [RW-1:0]    w_row_nxt, w_top_nxt, w_fill_nxt;
  logic [NW-1:0]    w_cnt_nxt;

  logic w_xfer, w_is_print, w_is_lf, w_is_cr, w_is_bs, w_is_ff;
  logic w_newline, w_scroll;
  logic [RW-1:0] w_row_inc, w_top_inc;

  // Physical cell address of (row, col) within the display RAM.
  function automatic logic [ADDRW-1:0] cell_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col);
    logic [31:0] a;
    a = BASE_ADDR + (32'(row) * COLS) + 32'(col);
    return a[ADDRW-1:0];
  endfunction

  // Linear address used while sweeping the whole screen.
  function automatic logic [ADDRW-1:0] lin_addr(input logic [NW-1:0] idx);
    logic [31:0] a;
    a = BASE_ADDR + 32'(idx);
    return a[ADDRW-1:0];
  endfunction

  assign w_xfer     = i_valid && r_ready;
  assign w_is_print = (i_data >= 8'h20) && (i_data <= 8'h7E);
  assign w_is_lf    = (i_data == 8'h0A);
  assign w_is_cr    = (i_data == 8'h0D);
  assign w_is_bs    = (i_data == 8'h08);
  assign w_is_ff    = (i_data == 8'h0C);

  // A newline comes from LF or from a printable landing in the last column;
  // it only scrolls once the screen is full.
  assign w_newline = w_xfer && (w_is_lf || (w_is_print && (r_col == LAST_COL)));
  assign w_scroll  = w_newline && (r_fill == LAST_ROW);
  assign w_row_inc = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
  assign w_top_inc = (r_top == LAST_ROW) ? '0 : r_top + 1'b1;

  // State register; reset lands in the full-screen clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_CLEAR_ALL;
    else       r_state <= w_state_nxt;
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer && w_is_ff) w_state_nxt = S_CLEAR_ALL;
        else if (w_scroll)     w_state_nxt = S_CLEAR_ROW;
      end
      S_CLEAR_ROW: if (r_cnt == COLS_N)  w_state_nxt = S_IDLE;
      S_CLEAR_ALL: if (r_cnt == CELLS_N) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_CLEAR_ALL;
    endcase
  end

  // Next values for the registered outputs, cursor and sweep counter.
  // A clear spends one extra cycle at the terminal count with no write so
  // that o_ready rises only in the cycle after the last blank is visible.
  always_comb begin
    w_we_nxt   = 1'b0;
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    w_top_nxt  = r_top;
    w_fill_nxt = r_fill;
    w_cnt_nxt  = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_is_print) begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = cell_addr(r_row, r_col);
            w_data_nxt = i_data;
            if (r_col != LAST_COL) w_col_nxt = r_col + 1'b1;
          end
          if (w_is_cr) w_col_nxt = '0;
          if (w_is_bs && (r_col != '0)) w_col_nxt = r_col - 1'b1;
          if (w_is_ff) begin
            // First blank goes out with the FF transfer itself.
            w_we_nxt   = 1'b1;
            w_addr_nxt = lin_addr('0);
            w_data_nxt = BLANK;
            w_cnt_nxt  = NW'(1);
          end
        end
        if (w_newline) begin
          w_col_nxt = '0;
          w_row_nxt = w_row_inc;
          if (w_scroll) begin
            w_top_nxt = w_top_inc;
            w_cnt_nxt = '0;
          end else begin
            w_fill_nxt = r_fill + 1'b1;
          end
        end
      end
      S_CLEAR_ROW: begin
        if (r_cnt != COLS_N) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = cell_addr(r_row, r_cnt[CW-1:0]);
          w_data_nxt = BLANK;
          w_cnt_nxt  = r_cnt + 1'b1;
        end
      end
      S_CLEAR_ALL: begin
        if (r_cnt != CELLS_N) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = lin_addr(r_cnt);
          w_data_nxt = BLANK;
          w_cnt_nxt  = r_cnt + 1'b1;
        end else begin
          w_col_nxt  = '0;
          w_row_nxt  = '0;
          w_top_nxt  = '0;
          w_fill_nxt = '0;
          w_cnt_nxt  = '0;
        end
      end
      default: ;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt  = !w_ready_nxt;
  end

  // Output and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_top   <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_top   <= w_top_nxt;
      r_fill  <= w_fill_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_ready      = r_ready;
  assign o_busy       = r_busy;
  assign o_write_en   = r_we;
  assign o_write_addr = r_addr;
  assign o_write_data = r_data;
  assign o_top_row    = r_top;
  assign o_cur_col    = r_col;
  assign o_cur_row    = r_row;

endmodule

// File: tb/tb_vdu_console_writer.sv
// Testbench for vdu_console_writer: two instances (60x34 at 0, 4x3 at 0x100)
// checked against a screen-level reference model of cursor, scroll and
// expected RAM write stream.
module tb_vdu_console_writer;

  localparam int C0 = 60, R0 = 34, B0 = 0;
  localparam int C1 = 4,  R1 = 3,  B1 = 'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        vld   [2];
  logic [7:0]  dat   [2];
  logic        rdy   [2];
  logic        we    [2];
  logic        busy  [2];
  logic [15:0] waddr [2];
  logic [7:0]  wdata [2];
  logic [7:0]  top   [2];
  logic [7:0]  col   [2];
  logic [7:0]  row   [2];

  logic [5:0] d0_top, d0_col, d0_row;
  logic [1:0] d1_top, d1_col, d1_row;

  vdu_console_writer #(.COLS(C0), .ROWS(R0), .BASE_ADDR(B0), .ADDRW(16), .BLANK(8'h20)) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_valid(vld[0]), .i_data(dat[0]), .o_ready(rdy[0]),
    .o_write_en(we[0]), .o_write_addr(waddr[0]), .o_write_data(wdata[0]),
    .o_top_row(d0_top), .o_cur_col(d0_col), .o_cur_row(d0_row), .o_busy(busy[0])
  );

  vdu_console_writer #(.COLS(C1), .ROWS(R1), .BASE_ADDR(B1), .ADDRW(16), .BLANK(8'h20)) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_valid(vld[1]), .i_data(dat[1]), .o_ready(rdy[1]),
    .o_write_en(we[1]), .o_write_addr(waddr[1]), .o_write_data(wdata[1]),
    .o_top_row(d1_top), .o_cur_col(d1_col), .o_cur_row(d1_row), .o_busy(busy[1])
  );

  assign top[0] = 8'(d0_top);
  assign col[0] = 8'(d0_col);
  assign row[0] = 8'(d0_row);
  assign top[1] = 8'(d1_top);
  assign col[1] = 8'(d1_col);
  assign row[1] = 8'(d1_row);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_col [2], m_row [2], m_top [2], m_fill [2];
  int q0 [$];
  int q1 [$];

  function automatic int g_cols(input int d); return (d == 0) ? C0 : C1; endfunction
  function automatic int g_rows(input int d); return (d == 0) ? R0 : R1; endfunction
  function automatic int g_base(input int d); return (d == 0) ? B0 : B1; endfunction

  function automatic void q_push(input int d, input int v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int q_pop(input int d);
    if (d == 0) return (q0.size() == 0) ? -1 : q0.pop_front();
    return (q1.size() == 0) ? -1 : q1.pop_front();
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void q_flush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic void m_push_cell(input int d, input int r, input int c, input int ch);
    int a;
    a = (g_base(d) + r * g_cols(d) + c) & 'hFFFF;
    q_push(d, (a << 8) | ch);
  endfunction

  function automatic void m_clear_all(input int d);
    for (int r = 0; r < g_rows(d); r++)
      for (int c = 0; c < g_cols(d); c++)
        m_push_cell(d, r, c, 'h20);
    m_col[d] = 0; m_row[d] = 0; m_top[d] = 0; m_fill[d] = 0;
  endfunction

  function automatic void m_newline(input int d);
    m_col[d] = 0;
    m_row[d] = (m_row[d] + 1) % g_rows(d);
    if (m_fill[d] < g_rows(d) - 1) m_fill[d]++;
    else begin
      m_top[d] = (m_top[d] + 1) % g_rows(d);
      for (int c = 0; c < g_cols(d); c++) m_push_cell(d, m_row[d], c, 'h20);
    end
  endfunction

  function automatic void m_byte(input int d, input int b);
    if (b >= 'h20 && b <= 'h7E) begin
      m_push_cell(d, m_row[d], m_col[d], b);
      if (m_col[d] == g_cols(d) - 1) m_newline(d);
      else m_col[d]++;
    end else if (b == 'h0A) m_newline(d);
    else if (b == 'h0D) m_col[d] = 0;
    else if (b == 'h08) begin
      if (m_col[d] > 0) m_col[d]--;
    end else if (b == 'h0C) m_clear_all(d);
  endfunction

  // ---------------- write monitor ----------------
  int cyc = 0;
  int wr_cnt [2], last_wr_cyc [2], rise_cyc [2];
  int last_addr [2], last_data [2];
  logic prev_rdy [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      wr_cnt[d] = 0; last_wr_cyc[d] = 0; rise_cyc[d] = 0;
      last_addr[d] = 0; last_data[d] = 0; prev_rdy[d] = 1'b0;
    end
  end

  // Every visible write must be the next one the model expects.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (we[d]) begin
        check_val((d == 0) ? "wr0" : "wr1", int'({waddr[d], wdata[d]}), q_pop(d));
        wr_cnt[d]      <= wr_cnt[d] + 1;
        last_wr_cyc[d] <= cyc;
        last_addr[d]   <= int'(waddr[d]);
        last_data[d]   <= int'(wdata[d]);
      end
      if (rdy[d] && !prev_rdy[d]) rise_cyc[d] <= cyc;
      prev_rdy[d] <= rdy[d];
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_cursor(input int d);
    check_val("col", int'(col[d]), m_col[d]);
    check_val("row", int'(row[d]), m_row[d]);
    check_val("top", int'(top[d]), m_top[d]);
  endtask

  task automatic send(input int d, input int b);
    int n;
    n = 0;
    vld[d] = 1'b1;
    dat[d] = 8'(b);
    while (!rdy[d] && n < 5000) begin step(); n++; end
    check_val("send_ready", int'(rdy[d]), 1);
    m_byte(d, b);
    step();
    vld[d] = 1'b0;
    if (b != 'h0C) check_cursor(d);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (!rdy[d] && n < 5000) begin step(); n++; end
    check_val("idle_ready", int'(rdy[d]), 1);
    check_val("idle_busy", int'(busy[d]), 0);
    check_val("idle_queue", q_size(d), 0);
    check_cursor(d);
  endtask

  task automatic check_reset(input int d);
    check_val("rst_we", int'(we[d]), 0);
    check_val("rst_addr", int'(waddr[d]), 0);
    check_val("rst_data", int'(wdata[d]), 0);
    check_val("rst_ready", int'(rdy[d]), 0);
    check_val("rst_busy", int'(busy[d]), 1);
    check_val("rst_top", int'(top[d]), 0);
    check_val("rst_col", int'(col[d]), 0);
    check_val("rst_row", int'(row[d]), 0);
  endtask

  function automatic int rand_byte();
    int r, v;
    r = $urandom_range(0, 199);
    if (r < 110) return $urandom_range('h20, 'h7E);
    if (r < 134) return 'h0A;
    if (r < 150) return 'h0D;
    if (r < 164) return 'h08;
    if (r < 165) return 'h0C;
    v = $urandom_range(0, 255);
    if ((v >= 'h20 && v <= 'h7E) || v == 'h0A || v == 'h0D || v == 'h08 || v == 'h0C) v = 'h7F;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int c, wc, n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; vld[d] = 1'b0; dat[d] = 8'h00;
    end
    repeat (3) step();
    check_reset(0);
    check_reset(1);
    m_clear_all(0);
    m_clear_all(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Power-up clear of both screens.
    drain(0);
    drain(1);
    check_val("init_wr_cnt0", wr_cnt[0], 2040);
    check_val("init_gap0", rise_cyc[0] - last_wr_cyc[0], 1);
    check_val("init_wr_cnt1", wr_cnt[1], 12);
    check_val("init_gap1", rise_cyc[1] - last_wr_cyc[1], 1);

    // Back-to-back printables.
    send(0, 'h41);
    c = last_wr_cyc[0];
    send(0, 'h42);
    check_val("ab_b2b", last_wr_cyc[0] - c, 1);
    check_val("ab_ready", int'(rdy[0]), 1);
    check_val("ab_col", int'(col[0]), 2);
    check_val("ab_addr", last_addr[0], 1);

    // Control codes: X CR Y BS BS LF Z from column 0.
    send(0, 'h0D);
    send(0, 'h58); send(0, 'h0D); send(0, 'h59); send(0, 'h08);
    send(0, 'h08); send(0, 'h0A); send(0, 'h5A);
    check_val("ctl_addr", last_addr[0], 60);
    check_val("ctl_data", last_data[0], 'h5A);
    check_val("ctl_col", int'(col[0]), 1);
    check_val("ctl_row", int'(row[0]), 1);

    // Form feed with the next byte held during the clear.
    send(0, 'h31); send(0, 'h32);
    send(0, 'h0C);
    vld[0] = 1'b1;
    dat[0] = 8'h51;
    n = 0;
    while (busy[0] && n < 5000) begin n++; step(); end
    check_val("ff_busy_cycles", n, 2040);
    check_val("ff_col", int'(col[0]), 0);
    check_val("ff_row", int'(row[0]), 0);
    check_val("ff_top", int'(top[0]), 0);
    send(0, 'h51);
    check_val("ff_held_addr", last_addr[0], 0);
    check_val("ff_held_data", last_data[0], 'h51);
    drain(0);

    // Small screen: 12 printables fill it and force a scroll.
    wc = wr_cnt[1];
    for (int i = 0; i < 12; i++) send(1, 'h61);
    check_val("scr_ready_low", int'(rdy[1]), 0);
    check_val("scr_top", int'(top[1]), 1);
    check_val("scr_last_addr", last_addr[1], 'h10B);
    c = last_wr_cyc[1];
    step();
    check_val("scr_blank_gap", last_wr_cyc[1] - c, 1);
    check_val("scr_blank_addr", last_addr[1], 'h100);
    check_val("scr_blank_data", last_data[1], 'h20);
    drain(1);
    check_val("scr_wr_cnt", wr_cnt[1] - wc, 16);

    // Reset in the middle of a row clear.
    for (int i = 0; i < 4; i++) send(1, 'h62);
    step();
    check_val("mid_busy", int'(busy[1]), 1);
    rst[1] = 1'b1;
    #1;
    check_reset(1);
    q_flush(1);
    m_clear_all(1);
    wc = wr_cnt[1];
    step();
    rst[1] = 1'b0;
    drain(1);
    check_val("mid_wr_cnt", wr_cnt[1] - wc, 12);
    check_val("mid_gap", rise_cyc[1] - last_wr_cyc[1], 1);

    // Randomized traffic on both geometries.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ((d == 0) ? 400 : 300); i++) begin
        send(d, rand_byte());
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        if ($urandom_range(0, 9) == 0) drain(d);
      end
      drain(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vdu_console_writer.md
Name: vdu_console_writer

Overview:
- Writer side of the VDU display-memory interface. Accepts a byte stream of character codes over a valid/ready handshake and writes glyph codes into the text RAM that the VDU reads.
- Maintains the cursor and handles CR, LF, BS and FF (form feed).
- Scrolls by rotating a circular top-row pointer, which the VDU adds to its row fetch, instead of copying RAM.
- Sits between a UART/CPU character source and the dual-port display RAM write port.

Parameters:
- COLS, 60, characters per row (480 px / 8).
- ROWS, 34, text rows (272 px / 8).
- BASE_ADDR, 0, display RAM address of physical row 0, column 0.
- ADDRW, 16, write address width.
- BLANK, 8'h20, fill code for cleared cells.

Ports:
- i_clk  in  1  system/pixel clock.
- i_rst  in  1  asynchronous active-high reset.
- i_valid  in  1  character byte valid.
- i_data  in  8  character code.
- o_ready  out  1  block can accept a byte this cycle.
- o_write_en  out  1  display RAM write strobe.
- o_write_addr  out  ADDRW  display RAM write address.
- o_write_data  out  8  display RAM write data.
- o_top_row  out  $clog2(ROWS)  physical row displayed at screen row 0.
- o_cur_col  out  $clog2(COLS)  cursor column.
- o_cur_row  out  $clog2(ROWS)  cursor physical row.
- o_busy  out  1  clearing in progress.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Reset values: o_write_en=0, o_write_addr=0, o_write_data=0, o_ready=0, o_top_row=0, o_cur_col=0, o_cur_row=0, o_busy=1, fill count=0.
- The FSM enters CLEAR_ALL on reset release.
- All outputs are registered.
- Address rule: addr = BASE_ADDR + phys_row*COLS + col, truncated to ADDRW.

FSM states:
- IDLE:
  - o_ready=1, o_busy=0.
  - A byte transfers when i_valid && o_ready in cycle N.
- CLEAR_ROW:
  - o_ready=0, o_busy=1.
  - Writes BLANK to COLS consecutive cells of the new cursor row, one per cycle, col 0..COLS-1.
  - Returns to IDLE in the cycle after the last write.
- CLEAR_ALL:
  - o_ready=0, o_busy=1.
  - Writes BLANK to addresses BASE_ADDR .. BASE_ADDR+ROWS*COLS-1 ascending, one per cycle.
  - Then sets cursor=(0,0), top_row=0, fill=0 and goes to IDLE.

Byte handling (accepted in cycle N):
- Printable 0x20-0x7E:
  - Cycle N+1: o_write_en=1, addr = cursor position, data=i_data.
  - Cursor advances col+1. At col==COLS-1 it wraps to col 0 and a newline is performed.
  - Back-to-back printables accepted every cycle while no newline/scroll is needed.
- LF 0x0A: newline. No write.
- CR 0x0D: col=0. No write.
- BS 0x08: col-1 if col>0, else unchanged. No reverse wrap, no write.
- FF 0x0C: enter CLEAR_ALL in N+1.
- All other codes, including 0x7F and 0x80-0xFF: consumed, no effect.

Newline:
- Cursor row advances modulo ROWS; col=0.
- If fill<ROWS-1: fill+1, no clear.
- Else (on the bottom screen row): o_top_row increments modulo ROWS, and the FSM enters CLEAR_ROW for the new cursor row.

Simultaneous and boundary events:
- A printable at col COLS-1 on the bottom row writes its char in N+1 and enters CLEAR_ROW in N+1. The first blank write is in N+2. o_ready is low from N+1.
- A write and a clear never occur in the same cycle.
- i_valid with o_ready=0 is ignored; the source must hold it.
- i_data is sampled only at transfer.
- Reset mid-clear aborts immediately and restarts CLEAR_ALL.
- Row wrap: cursor row ROWS-1 goes to row 0.

Test Plan:
- Reset release with COLS=60, ROWS=34:
  - Exactly 2040 writes of 0x20 at addr 0..2039.
  - o_ready rises in the cycle after the last write.
  - o_top_row=0.
- After init, send 'A','B' back-to-back:
  - writes (0,0x41) then (1,0x42) on consecutive cycles.
  - o_cur_col=2, o_ready stays 1.
- Send 'X', CR, 'Y', BS, BS, LF, 'Z':
  - writes (0,0x58), (0,0x59), (60,0x5A).
  - cursor ends (col 1, row 1).
- COLS=4, ROWS=3, BASE_ADDR=0x100: send 12 'a' (0x61):
  - Fills 0x100-0x10B.
  - The 12th write (0x10B) is followed by o_top_row=1 and four 0x20 writes at 0x100-0x103.
  - cursor (0,0).
- Mid-text FF:
  - o_busy=1 for ROWS*COLS cycles.
  - Then cursor (0,0), top_row 0.
  - o_ready is held low throughout, so a held i_valid byte is accepted only afterwards.
- Assert i_rst during CLEAR_ROW:
  - Outputs go to reset values without waiting for i_clk.
  - After release, a full CLEAR_ALL sequence from BASE_ADDR.
